// File: rtl/seq_multiplier_if.sv
// seq_multiplier_if: operand-accept and product-return handshake bundle for seq_multiplier
interface seq_multiplier_if;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  mode;
  logic [15:0] A;
  logic [15:0] B;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] product;
  logic        busy;
  modport master (
    output in_valid, mode, A, B, out_ready,
    input  in_ready, out_valid, product, busy
  );
  modport slave (
    input  in_valid, mode, A, B, out_ready,
    output in_ready, out_valid, product, busy
  );
endinterface

// File: rtl/seq_multiplier.sv
// seq_multiplier: shared shift-add datapath for unsigned 8x8, signed 8x8 and unsigned 16x16 products
module seq_multiplier (
  input logic             clock,
  input logic             reset,
  seq_multiplier_if.slave bus
);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t      state_q;
  logic [31:0] mcand_q, acc_q, product_q, acc_d, prod_d;
  logic [15:0] mplier_q, mag;
  logic [4:0]  cnt_q;
  logic        neg_q, sgn_q, wide_q, w16, sgn;
  logic [7:0]  a_abs, b_abs;
  always_comb begin
    w16    = bus.mode == 2'd2;
    sgn    = bus.mode == 2'd1;
    a_abs  = (sgn && bus.A[7]) ? ~bus.A[7:0] + 8'd1 : bus.A[7:0];
    b_abs  = (sgn && bus.B[7]) ? ~bus.B[7:0] + 8'd1 : bus.B[7:0];
    acc_d  = acc_q + (mplier_q[0] ? mcand_q : 32'd0);
    mag    = neg_q ? ~acc_d[15:0] + 16'd1 : acc_d[15:0];
    // only the signed mode sign-extends; unsigned 8x8 results can have bit 15 set
    prod_d = wide_q ? acc_d : {{16{sgn_q & mag[15]}}, mag};
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      product_q <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      neg_q     <= 1'b0;
      sgn_q     <= 1'b0;
      wide_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (bus.in_valid) begin
          state_q  <= CALC;
          mcand_q  <= w16 ? {16'b0, bus.A} : {24'b0, a_abs};
          mplier_q <= w16 ? bus.B : {8'b0, b_abs};
          acc_q    <= '0;
          cnt_q    <= w16 ? 5'd16 : 5'd8;
          neg_q    <= sgn & (bus.A[7] ^ bus.B[7]);
          sgn_q    <= sgn;
          wide_q   <= w16;
        end
        CALC: begin
          acc_q    <= acc_d;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q - 5'd1;
          if (cnt_q == 5'd1) begin
            product_q <= prod_d;
            state_q   <= DONE;
          end
        end
        DONE: if (bus.out_ready) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
  assign bus.in_ready  = state_q == IDLE;
  assign bus.out_valid = state_q == DONE;
  assign bus.busy      = state_q != IDLE;
  assign bus.product   = product_q;
endmodule

// File: tb/tb_seq_multiplier.sv
// tb_seq_multiplier: directed checks of latency, result formatting, backpressure and reset abort
module tb_seq_multiplier;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  seq_multiplier_if bus ();
  seq_multiplier dut (.clock(clk), .reset(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask
  task automatic start(input logic [1:0] m, input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    bus.mode = m; bus.A = a; bus.B = b; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask
  task automatic run(input string tag, input logic [1:0] m, input logic [15:0] a,
                     input logic [15:0] b, input int w, input logic [31:0] exp);
    int n = 0;
    start(m, a, b);
    chk({tag, "_busy"}, {31'b0, bus.busy}, 32'd1);
    chk({tag, "_in_ready_low"}, {31'b0, bus.in_ready}, 32'd0);
    while (!bus.out_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_latency"}, n, w);
    chk({tag, "_product"}, bus.product, exp);
  endtask
  task automatic drain(input string tag, input logic [31:0] exp);
    @(posedge clk); #1;
    chk({tag, "_idle_in_ready"}, {31'b0, bus.in_ready}, 32'd1);
    chk({tag, "_idle_out_valid"}, {31'b0, bus.out_valid}, 32'd0);
    chk({tag, "_product_held"}, bus.product, exp);
  endtask
  initial begin
    bus.in_valid = 1'b0; bus.mode = 2'd0; bus.A = '0; bus.B = '0; bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", {31'b0, bus.in_ready}, 32'd1);
    chk("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("rst_busy", {31'b0, bus.busy}, 32'd0);
    chk("rst_product", bus.product, 32'h0);
    rst = 1'b0;
    run("u8_ff", 2'd0, 16'h00FF, 16'h00FF, 8, 32'h0000FE01);
    drain("u8_ff", 32'h0000FE01);
    run("s8_m3x5", 2'd1, 16'h00FD, 16'h0005, 8, 32'hFFFFFFF1);
    drain("s8_m3x5", 32'hFFFFFFF1);
    run("s8_m128sq", 2'd1, 16'h0080, 16'h0080, 8, 32'h00004000);
    drain("s8_m128sq", 32'h00004000);
    run("u16_ffff", 2'd2, 16'hFFFF, 16'hFFFF, 16, 32'hFFFE0001);
    drain("u16_ffff", 32'hFFFE0001);
    bus.out_ready = 1'b0;
    run("m3_upper", 2'd3, 16'h1203, 16'h3404, 8, 32'h0000000C);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.in_valid = ~bus.in_valid; bus.mode = 2'(i); bus.A = 16'h5555; bus.B = 16'hAAAA;
      @(posedge clk); #1;
      chk("hold_out_valid", {31'b0, bus.out_valid}, 32'd1);
      chk("hold_product", bus.product, 32'h0000000C);
      chk("hold_in_ready", {31'b0, bus.in_ready}, 32'd0);
    end
    @(negedge clk);
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    drain("m3_upper", 32'h0000000C);
    start(2'd2, 16'h1234, 16'h5678);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_in_ready", {31'b0, bus.in_ready}, 32'd1);
    chk("abort_busy", {31'b0, bus.busy}, 32'd0);
    chk("abort_out_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("abort_product", bus.product, 32'h0);
    run("u8_7x9", 2'd0, 16'h0007, 16'h0009, 8, 32'h0000003F);
    drain("u8_7x9", 32'h0000003F);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/seq_multiplier.md
# seq_multiplier

Iterative shift-add multiplier that sits directly downstream of the operand-fetch controller and takes its A/B operand pairs and mode code. It replaces the combinational per-mode multipliers with a single shared datapath: unsigned 8x8, signed 8x8 and unsigned 16x16, one partial product per clock. Results go out over a valid/ready handshake to the product consumer.

## Interface
- No parameters. Widths are fixed: 16-bit operands, 32-bit product.
- clock  in  1  single clock for the whole block; all state updates on its rising edge.
- reset  in  1  synchronous, active-high; sampled on the rising edge of clock.
- in_valid  in  1  operand pair and mode are valid this cycle.
- in_ready  out  1  block can accept an operand pair (high only in IDLE).
- mode  in  2  0 = unsigned 8x8, 1 = signed 8x8, 2 = unsigned 16x16, 3 = same as 0.
- A  in  16  multiplicand; only A[7:0] is used in the 8-bit modes.
- B  in  16  multiplier; only B[7:0] is used in the 8-bit modes.
- out_valid  out  1  product is valid and held stable.
- out_ready  in  1  consumer accepts the product.
- product  out  32  result register.
- busy  out  1  high in the CALC and DONE states.

## Operation
- States: IDLE, CALC, DONE. All outputs except product are decoded from the state register.
- IDLE:
  - in_ready = 1.
  - When in_valid = 1 at an edge, the block captures mode, A and B and enters CALC.
- Capture (at the accept edge):
  - Operand width W = 8 for modes 0, 1 and 3; W = 16 for mode 2.
  - In the 8-bit modes the operands are A[7:0] and B[7:0]; the upper bits are ignored.
  - Mode 1: the block stores |A| and |B| as 8-bit magnitudes (-128 gives 128) and sets neg = A[7] ^ B[7].
  - Other modes: neg = 0.
  - The accumulator is cleared to 0 and the iteration counter is loaded with W.
- CALC, one iteration per edge:
  - If the multiplier LSB is 1, the multiplicand is added to the accumulator.
  - The multiplicand shifts left by 1, the multiplier shifts right by 1, and the counter decrements.
  - The accumulator is 32 bits wide, so the additions cannot overflow.
  - On the edge where the counter goes from 1 to 0, the result is written into product and the state goes to DONE.
- Result formatting:
  - Mode 0/3: product = {16'b0, A[7:0]*B[7:0]}.
  - Mode 1: the 16-bit magnitude is negated if neg = 1, then sign-extended to 32 bits.
  - Mode 2: product = the full 32-bit unsigned product.
- DONE:
  - out_valid = 1; product holds its value.
  - When out_ready = 1 at an edge, the state returns to IDLE.
  - Product keeps its last value until the next result overwrites it.
- in_valid outside IDLE is ignored; the upstream stage must hold its data until in_ready = 1.
- mode, A and B are sampled only at the accept edge. Changes to them during CALC or DONE have no effect.
- Reset:
  - Any edge with reset = 1 forces IDLE, clears product, the accumulator and the counter, and discards any operation in flight. This includes reset during CALC or DONE.
  - Reset takes priority over in_valid and out_ready on the same edge.
  - Values after reset: in_ready = 1, out_valid = 0, busy = 0, product = 0.

## Timing
- Accept at edge k; iterations at edges k+1 .. k+W; out_valid rises after edge k+W.
  - Latency from accept to out_valid is W cycles: 8 for the 8-bit modes, 16 for mode 2.
- If out_ready is already high, DONE lasts 1 cycle, then IDLE lasts at least 1 cycle.
  - Minimum initiation interval is W+2 cycles: 10 for 8-bit, 18 for 16-bit.
- While out_valid = 1 and out_ready = 0, DONE is held indefinitely and product is stable.
- No combinational path from any input to any output.

## Test plan
- Reset, then mode 0, A=0x00FF, B=0x00FF:
  - in_ready = 1 after reset.
  - out_valid exactly 8 cycles after accept, with product = 0x0000FE01.
- Mode 1, A=0x00FD (-3), B=0x0005 -> product = 0xFFFFFFF1.
- Mode 1, A=0x0080, B=0x0080 (-128 x -128) -> product = 0x00004000.
- Mode 2, A=0xFFFF, B=0xFFFF -> out_valid after 16 cycles, product = 0xFFFE0001.
- Mode 3, A=0x1203, B=0x3404 -> product = 0x0000000C (upper bits ignored, same as mode 0).
  - Hold out_ready = 0 for 5 cycles: out_valid stays 1, product is stable, in_ready stays 0.
  - Toggle in_valid and mode during this window: no effect.
- Assert reset at the 4th CALC cycle of a mode 2 operation:
  - Next cycle shows IDLE: in_ready = 1, busy = 0, out_valid = 0, product = 0.
  - A new mode 0 operation, 7 x 9, returns 0x0000003F after 8 cycles.
